// File: rtl/div32_seq.sv
// Sequential unsigned divider: restoring division, one quotient bit per clock, MSB first.
// A zero divisor skips the iterations and completes on the next cycle with dz_o set.
module div32_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quo_o,
  output logic [WIDTH-1:0] rem_o,
  output logic             dz_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] prem_reg;   // partial remainder between iterations (always < divisor)
  logic [WIDTH-1:0] dvd_reg;    // dividend bits shift out the top, quotient bits shift in the bottom
  logic [WIDTH-1:0] dsr_reg;

  logic             accept;
  logic             last_iter;
  logic [WIDTH:0]   prem_wide;
  logic [WIDTH:0]   trial;
  logic             q_bit;
  logic [WIDTH-1:0] prem_next;

  assign accept    = start_in && (state_reg == IDLE);
  assign last_iter = (cnt_reg == CW'(WIDTH - 1));

  // Trial subtraction on the WIDTH+1-bit shifted remainder; the top bit of the result is its sign.
  assign prem_wide = {prem_reg, dvd_reg[WIDTH-1]};
  assign trial     = prem_wide - {1'b0, dsr_reg};
  assign q_bit     = ~trial[WIDTH];
  assign prem_next = q_bit ? trial[WIDTH-1:0] : prem_wide[WIDTH-1:0];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy_o     = (state_reg != IDLE);
    done_o     = (state_reg == DONE);
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = (b_in == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_reg  <= '0;
      prem_reg <= '0;
      dvd_reg  <= '0;
      dsr_reg  <= '0;
      quo_o    <= '0;
      rem_o    <= '0;
      dz_o     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept && (b_in != '0)) begin
            cnt_reg  <= '0;
            prem_reg <= '0;
            dvd_reg  <= a_in;
            dsr_reg  <= b_in;
          end else if (accept) begin
            quo_o <= '1;
            rem_o <= a_in;
            dz_o  <= 1'b1;
          end
        end
        BUSY: begin
          cnt_reg  <= cnt_reg + 1'b1;
          prem_reg <= prem_next;
          dvd_reg  <= {dvd_reg[WIDTH-2:0], q_bit};
          if (last_iter) begin
            quo_o <= {dvd_reg[WIDTH-2:0], q_bit};
            rem_o <= prem_next;
            dz_o  <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
